// File: rtl/get_certificate_request_pkg.sv
// Shared auth definitions for the GET_CERTIFICATE requester: message layout, opcodes, error codes.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package get_certificate_request_pkg;

  // Request/answer messages are a 32-bit header followed by the body.
  localparam int MSG_LEN     = 128;
  localparam int HDR_LEN     = 32;
  localparam int PAYLOAD_LEN = MSG_LEN - HDR_LEN;
  localparam int HDR_FIELD_W = 8;

  localparam logic [HDR_FIELD_W-1:0] PROTOCOL_VERSION       = 8'h12;
  localparam logic [HDR_FIELD_W-1:0] GET_CERTIFICATE_CMD    = 8'h82;
  localparam logic [HDR_FIELD_W-1:0] CERTIFICATE_ANSWER_CMD = 8'h02;

  typedef enum logic [1:0] {
    ERR_RESPONDER = 2'd0,
    ERR_HEADER    = 2'd1,
    ERR_LENGTH    = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_DELIVER,
    ST_FINISH,
    ST_ABORT
  } state_e;

  typedef struct packed {
    logic [HDR_FIELD_W-1:0] version;
    logic [HDR_FIELD_W-1:0] cmd;
    logic [HDR_FIELD_W-1:0] param1;
    logic [HDR_FIELD_W-1:0] param2;
  } msg_hdr_t;

  // Unsigned 16-bit minimum, used to clip the last chunk to the remaining bytes.
  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/get_certificate_request_builder.sv
// Packs a GET_CERTIFICATE request from slot, offset and length.
// Latency: purely combinational.
// Backpressure: none; the caller holds its inputs stable while the request is pending.
module get_certificate_req_builder
  import get_certificate_request_pkg::*;
(
  input  logic [1:0]         slot_i,
  input  logic [15:0]        offset_i,
  input  logic [15:0]        length_i,
  output logic [MSG_LEN-1:0] msg_o
);

  msg_hdr_t hdr;

  // Header carries the slot in param1; body is offset, length, then zero fill.
  always_comb begin
    hdr.version = PROTOCOL_VERSION;
    hdr.cmd     = GET_CERTIFICATE_CMD;
    hdr.param1  = {6'b0, slot_i};
    hdr.param2  = 8'h00;
    msg_o       = {hdr, offset_i, length_i, {(MSG_LEN - HDR_LEN - 32){1'b0}}};
  end

endmodule

// File: rtl/get_certificate_request.sv
// Reads a certificate chain in chunks: issues GET_CERTIFICATE requests and checks each answer.
// Latency: Start to first Req_valid 1 cycle; Resp_ack to Chunk_valid 1 cycle.
// Backpressure: Req_msg held stable until Req_ready; answers awaited up to TIMEOUT_CYCLES.
module get_certificate_request
  import get_certificate_request_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   Start,
  input  logic [1:0]             Slot,
  input  logic [15:0]            Total_len,
  input  logic [15:0]            Chunk_len,
  output logic                   Req_valid,
  output logic [MSG_LEN-1:0]     Req_msg,
  input  logic                   Req_ready,
  input  logic                   Resp_ack,
  input  logic [31:0]            Resp_header,
  input  logic                   Resp_error,
  input  logic [15:0]            Resp_wLength,
  input  logic [PAYLOAD_LEN-1:0] Resp_payload,
  output logic                   Chunk_valid,
  output logic [PAYLOAD_LEN-1:0] Chunk_data,
  output logic [15:0]            Chunk_offset,
  output logic [15:0]            Chunk_length,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [1:0]             Error_code
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             slot_q, slot_d;
  logic [15:0]            total_q, total_d;
  logic [15:0]            chunk_q, chunk_d;
  logic [15:0]            offset_q, offset_d;
  logic [15:0]            len_q, len_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PAYLOAD_LEN-1:0] data_q, data_d;
  logic [15:0]            coff_q, coff_d;
  logic [15:0]            clen_q, clen_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   zerr_q, zerr_d;

  logic [15:0]            next_off;
  logic [MSG_LEN-1:0]     built_msg;
  logic [7:0]             resp_cmd;
  logic [7:0]             resp_param1;
  logic [15:0]            unused_hdr_bits;

  assign resp_cmd        = Resp_header[23:16];
  assign resp_param1     = Resp_header[15:8];
  // Version and param2 of the answer are not part of the acceptance check.
  assign unused_hdr_bits = {Resp_header[31:24], Resp_header[7:0]};
  assign next_off        = offset_q + len_q;

  get_certificate_req_builder u_builder (
    .slot_i   (slot_q),
    .offset_i (offset_q),
    .length_i (len_q),
    .msg_o    (built_msg)
  );

  // Next-state and datapath updates; Start is only honoured in IDLE.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    total_d    = total_q;
    chunk_d    = chunk_q;
    offset_d   = offset_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    coff_d     = coff_q;
    clen_d     = clen_q;
    err_code_d = err_code_q;
    zerr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if ((Total_len != 16'd0) && (Chunk_len != 16'd0)) begin
            slot_d     = Slot;
            total_d    = Total_len;
            chunk_d    = Chunk_len;
            offset_d   = 16'd0;
            len_d      = min16(Chunk_len, Total_len);
            err_code_d = ERR_RESPONDER;
            state_d    = ST_SEND;
          end else begin
            // Nothing to read: report a length error without leaving IDLE.
            zerr_d     = 1'b1;
            err_code_d = ERR_LENGTH;
          end
        end
      end
      ST_SEND: begin
        if (Req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (Resp_ack) begin
          if (Resp_error) begin
            err_code_d = ERR_RESPONDER;
            state_d    = ST_ABORT;
          end else if ((resp_cmd != CERTIFICATE_ANSWER_CMD) ||
                       (resp_param1 != {6'b0, slot_q})) begin
            err_code_d = ERR_HEADER;
            state_d    = ST_ABORT;
          end else if (Resp_wLength != len_q) begin
            err_code_d = ERR_LENGTH;
            state_d    = ST_ABORT;
          end else begin
            data_d  = Resp_payload;
            coff_d  = offset_q;
            clen_d  = len_q;
            state_d = ST_DELIVER;
          end
        end else if (cnt_q == CNT_TERM) begin
          // An answer arriving on this same cycle takes the branch above instead.
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DELIVER: begin
        offset_d = next_off;
        len_d    = min16(chunk_q, total_q - next_off);
        state_d  = (next_off == total_q) ? ST_FINISH : ST_SEND;
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      total_q    <= '0;
      chunk_q    <= '0;
      offset_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      coff_q     <= '0;
      clen_q     <= '0;
      err_code_q <= '0;
      zerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      total_q    <= total_d;
      chunk_q    <= chunk_d;
      offset_q   <= offset_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      coff_q     <= coff_d;
      clen_q     <= clen_d;
      err_code_q <= err_code_d;
      zerr_q     <= zerr_d;
    end
  end

  // Status and strobes decode from the state; the request is zeroed when not offered.
  always_comb begin
    Busy         = (state_q != ST_IDLE);
    Req_valid    = (state_q == ST_SEND);
    Req_msg      = Req_valid ? built_msg : '0;
    Chunk_valid  = (state_q == ST_DELIVER);
    Chunk_data   = data_q;
    Chunk_offset = coff_q;
    Chunk_length = clen_q;
    Done         = (state_q == ST_FINISH);
    Error        = (state_q == ST_ABORT) || zerr_q;
    Error_code   = err_code_q;
  end

endmodule

// File: doc/get_certificate_request.md
GET_CERTIFICATE_REQUEST -- requirements
Module: get_certificate_request

Interface
REQ-001 Parameters (name, default, meaning): TIMEOUT_CYCLES, 1024, max cycles in WAIT_RESP before abort; CNT_W, 11, timeout counter width.
REQ-002 clk  in  1  rising-edge clock, single domain.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 Start  in  1  one-cycle pulse; begins a chain read; ignored unless IDLE.
REQ-005 Slot  in  2  certificate slot (0..2) to read; sampled on Start.
REQ-006 Total_len  in  16  chain length in bytes; sampled on Start.
REQ-007 Chunk_len  in  16  max bytes per request; sampled on Start.
REQ-008 Req_valid  out  1  request message valid.
REQ-009 Req_msg  out  MSG_LEN  {PROTOCOL_VERSION, GET_CERTIFICATE_CMD, Slot, 8'h00, offset[15:0], length[15:0], zeros}.
REQ-010 Req_ready  in  1  responder accepts Req_msg when high with Req_valid.
REQ-011 Resp_ack  in  1  responder answer valid (one cycle).
REQ-012 Resp_header  in  32  answer header {version, cmd, param1, param2}.
REQ-013 Resp_error  in  1  responder Invalid Request flag, qualified by Resp_ack.
REQ-014 Resp_wLength  in  16  answer payload length, qualified by Resp_ack.
REQ-015 Resp_payload  in  MSG_LEN-32  answer payload.
REQ-016 Chunk_valid  out  1  one-cycle strobe: chunk delivered.
REQ-017 Chunk_data  out  MSG_LEN-32  registered payload of delivered chunk.
REQ-018 Chunk_offset / Chunk_length  out  16 each  offset and length of delivered chunk.
REQ-019 Busy, Done, Error  out  1 each  status; Done/Error are one-cycle pulses.
REQ-020 Error_code  out  2  0 responder error, 1 header mismatch, 2 length mismatch, 3 timeout; held until next Start.

Function
REQ-021 FSM states IDLE, SEND, WAIT_RESP, DELIVER, FINISH, ABORT; Busy=1 in all but IDLE.
REQ-022 IDLE: Start with Total_len!=0 and Chunk_len!=0 -> latch inputs, offset=0, go SEND; else Start with zero length -> Error pulse, code 2, stay IDLE.
REQ-023 Request length = min(Chunk_len, Total_len-offset), computed in 16 bits, registered on entry to SEND.
REQ-024 SEND: Req_valid=1, Req_msg stable until Req_valid&&Req_ready; handshake cycle -> WAIT_RESP, timeout counter cleared.
REQ-025 WAIT_RESP: Resp_ack checked in priority order: Resp_error -> code 0; header cmd!=CERTIFICATE_ANSWER_CMD or param1!=Slot -> code 1; Resp_wLength!=request length -> code 2; else capture payload, go DELIVER.
REQ-026 WAIT_RESP counter increments each cycle without Resp_ack; reaching TIMEOUT_CYCLES -> code 3, ABORT; Resp_ack on the terminal cycle wins over timeout.
REQ-027 Resp_ack outside WAIT_RESP is ignored.
REQ-028 DELIVER: Chunk_valid=1 for one cycle; offset += length; if new offset == Total_len -> FINISH, else SEND.
REQ-029 FINISH: Done=1 one cycle -> IDLE. ABORT: Error=1 one cycle -> IDLE.
REQ-030 Start while Busy is ignored; no request queuing.
REQ-031 Offset never exceeds Total_len; last chunk is shortened, not padded.
REQ-032 Latency: Start to first Req_valid = 1 cycle; Resp_ack to Chunk_valid = 1 cycle.

Reset
REQ-033 reset_n low asynchronously forces IDLE and all outputs, counters, latched inputs to 0.
REQ-034 Reset mid-transfer drops Req_valid immediately; no Done/Error pulse emitted.

Structure
REQ-035 MSG_LEN, header field widths, PROTOCOL_VERSION, GET_CERTIFICATE_CMD, CERTIFICATE_ANSWER_CMD, error codes live in the shared auth defines/package.
REQ-036 One sub-module natural: get_certificate_req_builder (combinational Req_msg packing from slot/offset/length).

Verification
REQ-037 Slot 0, Total_len 600, Chunk_len 256, ideal responder -> requests (0,256),(256,256),(512,88), three Chunk_valid, Done.
REQ-038 Req_ready held low 5 cycles -> Req_msg stable, single request, no duplicate.
REQ-039 Responder Resp_error=1 on second request -> Error pulse, Error_code 0, Busy low next cycle.
REQ-040 Resp_header param1=1 while Slot=2 -> Error_code 1; Resp_wLength 100 vs 256 -> Error_code 2.
REQ-041 No Resp_ack for TIMEOUT_CYCLES=16 -> Error_code 3 after exactly 16 WAIT_RESP cycles.
REQ-042 reset_n low during WAIT_RESP -> outputs 0 asynchronously; fresh Start afterwards restarts at offset 0.
